// File: rtl/mips_exec_ctrl_pkg.sv
// Shared command bytes, controller state encoding and a saturating counter helper
// for the MIPS execution controller.
package mips_exec_ctrl_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h43;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LEN,
    LOAD_BYTE,
    LOAD_WRITE,
    CPU_RST,
    RUN,
    STEP,
    DONE
  } ctrl_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mips_exec_ctrl_byte_word_packer.sv
// Little-endian 4-byte assembler: the first byte lands in [7:0]; word_complete
// flags the byte that fills the word so the controller can write it next cycle.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0] byte_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      word     <= 32'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      word     <= 32'd0;
    end else if (byte_valid) begin
      word[{byte_idx, 3'b000} +: 8] <= byte_data;
      byte_idx                      <= byte_idx + 2'd1;
    end
  end

  assign word_complete = byte_valid && (byte_idx == 2'd3);

endmodule

// File: rtl/mips_exec_ctrl.sv
// Execution controller for the pipelined MIPS core: loads instruction memory from
// a byte command stream, pulses the core reset and runs or single-steps the core.
module mips_exec_ctrl
  import mips_exec_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W    = 8,
  parameter int unsigned CPU_RST_CYCLES = 2,
  parameter int unsigned MAX_RUN_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_cmd_valid,
  input  logic [7:0]             i_cmd_data,
  output logic                   o_cmd_ready,
  input  logic                   i_cpu_halt,
  output logic                   o_cpu_en,
  output logic                   o_cpu_reset,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_wdata,
  output logic [31:0]            o_cycle_count,
  output logic                   o_halted,
  output logic                   o_timeout,
  output logic                   o_done,
  output logic                   o_busy
);

  localparam int unsigned RST_LAST = (CPU_RST_CYCLES > 0) ? CPU_RST_CYCLES - 1 : 0;

  ctrl_state_t            state, state_next;
  logic                   accept;
  logic                   pk_valid, pk_clear, pk_complete;
  logic [31:0]            pk_word;
  logic [IMEM_ADDR_W-1:0] word_addr;
  logic [8:0]             words_left;
  logic [15:0]            rst_cnt;
  logic [31:0]            count_inc, run_count_next;
  logic                   wd_hit, enter_rst, flags_block;

  assign accept      = i_cmd_valid && o_cmd_ready;
  assign pk_valid    = accept && (state == LOAD_BYTE);
  assign pk_clear    = (state == LOAD_LEN) || (state == LOAD_WRITE);
  assign flags_block = o_halted || o_timeout;

  byte_word_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (pk_clear),
    .byte_valid    (pk_valid),
    .byte_data     (i_cmd_data),
    .word          (pk_word),
    .word_complete (pk_complete)
  );

  // A count already at or past the limit also trips the watchdog, so a run
  // started after many steps cannot spin until the counter saturates.
  assign count_inc      = sat_inc(o_cycle_count);
  assign run_count_next = i_cpu_halt ? o_cycle_count : count_inc;
  assign wd_hit         = (MAX_RUN_CYCLES != 0) && (run_count_next >= 32'(MAX_RUN_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (i_cmd_data)
            CMD_LOAD:  state_next = LOAD_LEN;
            CMD_RUN:   state_next = flags_block ? IDLE : RUN;
            CMD_STEP:  state_next = flags_block ? IDLE : STEP;
            CMD_CLEAR: state_next = CPU_RST;
            default:   state_next = IDLE;
          endcase
        end
      end
      LOAD_LEN:   if (accept) state_next = LOAD_BYTE;
      LOAD_BYTE:  if (pk_complete) state_next = LOAD_WRITE;
      LOAD_WRITE: state_next = (words_left == 9'd1) ? CPU_RST : LOAD_BYTE;
      CPU_RST:    if (rst_cnt == 16'd0) state_next = IDLE;
      RUN:        if (i_cpu_halt || wd_hit) state_next = DONE;
      STEP:       state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  assign enter_rst = (state_next == CPU_RST) && (state != CPU_RST);

  // Load bookkeeping: a length byte of zero means a full 256-word image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_addr  <= '0;
      words_left <= 9'd0;
    end else if (state == LOAD_LEN && accept) begin
      word_addr  <= '0;
      words_left <= (i_cmd_data == 8'd0) ? 9'd256 : {1'b0, i_cmd_data};
    end else if (state == LOAD_WRITE) begin
      word_addr  <= word_addr + IMEM_ADDR_W'(1);
      words_left <= words_left - 9'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_cnt       <= 16'd0;
      o_cycle_count <= 32'd0;
      o_halted      <= 1'b0;
      o_timeout     <= 1'b0;
    end else if (enter_rst) begin
      rst_cnt       <= 16'(RST_LAST);
      o_cycle_count <= 32'd0;
      o_halted      <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      if (state == CPU_RST && rst_cnt != 16'd0) rst_cnt <= rst_cnt - 16'd1;
      if (state == RUN) begin
        o_cycle_count <= run_count_next;
        if (i_cpu_halt) o_halted  <= 1'b1;
        if (wd_hit)     o_timeout <= 1'b1;
      end
      if (state == STEP) begin
        if (i_cpu_halt) o_halted      <= 1'b1;
        else            o_cycle_count <= count_inc;
      end
    end
  end

  assign o_cmd_ready  = (state == IDLE) || (state == LOAD_LEN) || (state == LOAD_BYTE);
  assign o_cpu_en     = (state == RUN) || (state == STEP);
  assign o_cpu_reset  = (state == CPU_RST);
  assign o_imem_we    = (state == LOAD_WRITE);
  assign o_imem_addr  = word_addr;
  assign o_imem_wdata = pk_word;
  assign o_done       = (state == DONE);
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Scoreboard bench for mips_exec_ctrl: command-level reference model and a toy
// core that halts after a chosen number of enabled cycles.
module tb_mips_exec_ctrl;

  localparam int unsigned MAX_RUN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_cmd_valid;
  logic [7:0]  i_cmd_data;
  logic        o_cmd_ready;
  logic        i_cpu_halt;
  logic        o_cpu_en, o_cpu_reset, o_imem_we;
  logic [7:0]  o_imem_addr;
  logic [31:0] o_imem_wdata, o_cycle_count;
  logic        o_halted, o_timeout, o_done, o_busy;

  mips_exec_ctrl #(.IMEM_ADDR_W(8), .CPU_RST_CYCLES(2), .MAX_RUN_CYCLES(MAX_RUN)) dut (
    .clk(clk), .reset(reset), .i_cmd_valid(i_cmd_valid), .i_cmd_data(i_cmd_data),
    .o_cmd_ready(o_cmd_ready), .i_cpu_halt(i_cpu_halt), .o_cpu_en(o_cpu_en),
    .o_cpu_reset(o_cpu_reset), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_cycle_count(o_cycle_count), .o_halted(o_halted),
    .o_timeout(o_timeout), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Toy core: advances while enabled and not halted; halts once it has executed
  // halt_point instructions since its last reset.
  int unsigned core_cycles = 0;
  int unsigned halt_point  = 0;
  always @(posedge clk) begin
    if (o_cpu_reset) core_cycles <= 0;
    else if (o_cpu_en && !i_cpu_halt) core_cycles <= core_cycles + 1;
  end
  assign i_cpu_halt = (core_cycles >= halt_point);

  typedef struct {
    int          kind;   // 0 write, 1 core reset, 2 done
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic        h;
    logic        t;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          en_run = 0;
  int          rst_run = 0;
  logic [31:0] load_words[256];

  int unsigned m_count = 0;
  int unsigned m_core = 0;
  logic        m_halted = 1'b0;
  logic        m_timeout = 1'b0;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event expected=none", name);
  endtask

  // Monitor: sampled on the falling edge, pops the scoreboard on each DUT event.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      en_run  = 0;
      rst_run = 0;
    end else begin
      if (o_cpu_en) en_run++;
      if (o_cpu_reset) rst_run++;
      else if (rst_run != 0) begin
        if (sb_q.size() == 0) failNow("unexpected_core_reset");
        else begin
          e = sb_q.pop_front();
          checkOutput("rst_kind", 96'(e.kind), 96'd1);
          checkOutput("rst_len_state", {rst_run, o_cycle_count, o_halted, o_timeout},
                      {32'd2, 32'd0, 1'b0, 1'b0});
        end
        rst_run = 0;
      end
      if (o_imem_we) begin
        if (sb_q.size() == 0) failNow("unexpected_write");
        else begin
          e = sb_q.pop_front();
          checkOutput("write", {32'(e.kind), 24'd0, o_imem_addr, o_imem_wdata},
                      {32'd0, e.a, e.b});
        end
      end
      if (o_done) begin
        if (sb_q.size() == 0) failNow("unexpected_done");
        else begin
          e = sb_q.pop_front();
          checkOutput("done_en_cycles", {32'(e.kind), en_run}, {32'd2, e.cycles});
          checkOutput("done_state", {o_cycle_count, o_halted, o_timeout}, {e.a, e.h, e.t});
        end
        en_run = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    i_cmd_valid = 1'b1;
    i_cmd_data  = b;
    while (!o_cmd_ready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    i_cmd_data  = $urandom;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic waitReady();
    while (!o_cmd_ready) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdle();
    int k = 0;
    while ((sb_q.size() != 0 || o_busy) && k < 5000) begin @(posedge clk); #1; k++; end
    if (k >= 5000) failNow("drain_timeout");
  endtask

  task automatic sendLoad(input int n, input int unsigned hp);
    exp_t e;
    int cnt = (n == 0) ? 256 : n;
    waitReady();
    halt_point = hp;
    applyStimulus(8'h4C);
    applyStimulus(8'(n));
    for (int w = 0; w < cnt; w++) begin
      e = '{kind: 0, a: 32'(w % 256), b: load_words[w], cycles: 0, h: 1'b0, t: 1'b0};
      sb_q.push_back(e);
      for (int b = 0; b < 4; b++) applyStimulus(load_words[w][8*b +: 8]);
    end
    e = '{kind: 1, a: 0, b: 0, cycles: 0, h: 1'b0, t: 1'b0};
    sb_q.push_back(e);
    m_count = 0; m_core = 0; m_halted = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic sendClear(input int unsigned hp);
    exp_t e;
    waitReady();
    halt_point = hp;
    e = '{kind: 1, a: 0, b: 0, cycles: 0, h: 1'b0, t: 1'b0};
    sb_q.push_back(e);
    m_count = 0; m_core = 0; m_halted = 1'b0; m_timeout = 1'b0;
    applyStimulus(8'h43);
  endtask

  // Run outcome in closed form: n instructions remain before halt, t more
  // counted cycles trip the watchdog; whichever comes first ends the run.
  task automatic sendRun();
    exp_t e;
    int unsigned n, t;
    waitReady();
    if (!(m_halted || m_timeout)) begin
      n = (halt_point > m_core) ? halt_point - m_core : 0;
      t = (m_count >= MAX_RUN) ? 1 : MAX_RUN - m_count;
      e = '{kind: 2, a: 0, b: 0, cycles: 0, h: 1'b0, t: 1'b0};
      if (n < t) begin
        e.cycles = n + 1;
        m_count += n; m_core += n;
        m_halted = 1'b1;
        if (n == 0 && m_count >= MAX_RUN) m_timeout = 1'b1;
      end else begin
        e.cycles = t;
        m_count += t; m_core += t;
        m_timeout = 1'b1;
      end
      e.a = m_count; e.h = m_halted; e.t = m_timeout;
      sb_q.push_back(e);
    end
    applyStimulus(8'h52);
  endtask

  task automatic sendStep();
    exp_t e;
    waitReady();
    if (!(m_halted || m_timeout)) begin
      if (m_core >= halt_point) m_halted = 1'b1;
      else begin m_count++; m_core++; end
      e = '{kind: 2, a: m_count, b: 0, cycles: 1, h: m_halted, t: m_timeout};
      sb_q.push_back(e);
    end
    applyStimulus(8'h53);
  endtask

  task automatic sendJunk(input logic [7:0] b);
    waitReady();
    applyStimulus(b);
  endtask

  initial begin
    logic [7:0] junk;
    reset = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {o_cmd_ready, o_cpu_en, o_cpu_reset, o_imem_we, o_imem_addr, o_imem_wdata,
                 o_cycle_count, o_halted, o_timeout, o_done, o_busy},
                {1'b1, 79'd0});
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    load_words[0] = 32'h05000820;
    load_words[1] = 32'hFC000000;
    sendLoad(2, 5);
    waitIdle();
    checkOutput("load_count_zero", {o_cycle_count, o_busy}, {32'd0, 1'b0});

    sendRun();
    sendRun();
    waitIdle();
    checkOutput("halt_flags", {o_cycle_count, o_halted, o_timeout, o_busy}, {32'd5, 3'b100});
    checkOutput("no_stray_enable", 96'(en_run), 96'd0);

    sendClear(1000);
    repeat (3) sendStep();
    waitIdle();
    checkOutput("step_count", {o_cycle_count, o_halted}, {32'd3, 1'b0});

    sendClear(1000);
    sendRun();
    waitIdle();
    checkOutput("watchdog", {o_cycle_count, o_halted, o_timeout}, {32'd10, 2'b01});

    sendJunk(8'h7F);
    waitIdle();
    checkOutput("unknown_byte", {o_cmd_ready, o_busy, 32'(en_run)}, {1'b1, 1'b0, 32'd0});

    sendClear(4);
    waitIdle();
    waitReady();
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    #2 reset = 1'b1;
    #1;
    checkOutput("midload_reset",
                {o_cmd_ready, o_cpu_en, o_cpu_reset, o_imem_we, o_imem_addr, o_imem_wdata,
                 o_cycle_count, o_halted, o_timeout, o_done, o_busy},
                {1'b1, 79'd0});
    m_count = 0; m_halted = 1'b0; m_timeout = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    load_words[0] = $urandom;
    sendLoad(1, 3);
    waitIdle();

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          for (int w = 0; w < 3; w++) load_words[w] = $urandom;
          sendLoad($urandom_range(1, 3), $urandom_range(0, 12));
        end
        2, 3, 4: sendRun();
        5, 6:    sendStep();
        7:       sendClear($urandom_range(0, 15));
        default: begin
          junk = 8'($urandom);
          while (junk == 8'h4C || junk == 8'h52 || junk == 8'h53 || junk == 8'h43)
            junk = 8'($urandom);
          sendJunk(junk);
        end
      endcase
    end
    waitIdle();

    for (int w = 0; w < 256; w++) load_words[w] = $urandom;
    sendLoad(0, 3);
    sendRun();
    waitIdle();
    checkOutput("final_idle", {32'(sb_q.size()), 32'(en_run), o_busy}, {65'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    failNow("global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
